// File: rtl/rca_seq_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and the helper that sizes the nibble index counter.
package rca_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Plain 4-bit ripple-carry adder; the single arithmetic element reused by the
// nibble-serial sequencer.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/rca_nibble_seq.sv
// Multi-cycle WIDTH-bit adder that steps one 4-bit ripple adder through the
// operands LS nibble first. Define RCA_NIBBLE_SEQ_SUB_EN to add a subtract input.
module rca_nibble_seq
  import rca_seq_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_NIBBLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int                IDX_W    = clog2_min1(NIBBLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg;

  logic [WIDTH-1:0]  b_load;
  logic              carry_load;
  logic              accept, last;
  logic [NIBBLE_W-1:0] add_a, add_b, add_sum;
  logic              add_cout;

  // Subtraction is a + ~b + 1: invert B at capture time and force the carry-in.
`ifdef RCA_NIBBLE_SEQ_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDX_LAST);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  assign add_a = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign add_b = b_reg[idx*NIBBLE_W +: NIBBLE_W];

  ripple_carry_adder_4bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: the register uses non-blocking assignment so every flop samples
  // pre-edge values; reset here is synchronous, sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            idx       <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
          end
        end
        RUN: begin
          sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= add_sum;
          carry_reg                         <= add_cout;
          if (last) begin
            cout_reg <= add_cout;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Self-checking bench for rca_nibble_seq (WIDTH=16): directed cases plus
// randomized operations checked against a plain-arithmetic reference.
module tb_rca_nibble_seq;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef RCA_NIBBLE_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rca_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef RCA_NIBBLE_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, latency, optional output stall, handshake.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_cin, input logic op_sub, input int stall);
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic [WIDTH:0]   full;
    int               w, lat;
    if (op_sub) begin
      exp_sum  = op_a - op_b;
      exp_cout = (op_a >= op_b);
    end else begin
      full     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
      exp_sum  = full[WIDTH-1:0];
      exp_cout = full[WIDTH];
    end
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
`ifdef RCA_NIBBLE_SEQ_SUB_EN
    sub      = op_sub;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    check("accept_ready", in_ready, 1);
    step();
    // Operands offered after accept must be ignored.
    in_valid = (stall > 0);
    a        = ~op_a;
    b        = op_b ^ 16'h5A5A;
    cin      = ~op_cin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("busy_run", busy, 1);
      step();
      lat++;
    end
    check("latency", lat, LAT);
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
    check("in_ready_done", in_ready, 0);
    check("busy_done", busy, 1);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_sum", sum, exp_sum);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_busy", busy, 0);
    check("post_sum_held", sum, exp_sum);
    check("post_cout_held", cout, exp_cout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic rsub;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef RCA_NIBBLE_SEQ_SUB_EN
    sub       = 1'b0;
`endif
    step();
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready_idle", in_ready, 1);

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 3);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
`ifdef RCA_NIBBLE_SEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
`endif

    // Reset in the middle of an operation discards it.
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("midrst_no_result", seen, 0);

    // Back-to-back with in_valid held and out_ready high.
    a = 16'h0001;
    b = 16'h0002;
    cin = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_ready1", in_ready, 1);
    step();
    a = 16'h8000;
    b = 16'h8000;
    seen = 0;
    while (!out_valid && seen < 20) begin
      step();
      seen++;
    end
    check("b2b_lat1", seen, LAT);
    check("b2b_sum1", sum, 16'h0003);
    check("b2b_cout1", cout, 0);
    step();
    check("b2b_ready2", in_ready, 1);
    check("b2b_idle_sum_held", sum, 16'h0003);
    step();
    check("b2b_busy2", busy, 1);
    seen = 0;
    while (!out_valid && seen < 20) begin
      step();
      seen++;
    end
    check("b2b_lat2", seen, LAT);
    check("b2b_sum2", sum, 16'h0000);
    check("b2b_cout2", cout, 1);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("b2b_post_valid", out_valid, 0);

    for (int n = 0; n < 40; n++) begin
      rsub = 1'b0;
`ifdef RCA_NIBBLE_SEQ_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`endif
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), rsub,
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
